imem_fetch_ctrl: RTL

//  Fetch sequencer for the read-only instruction memory: owns the PC, drives the memory address,

---
 rtl/imem_fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer between the read-only instruction memory and decode: owns the PC, waits out
// the memory latency, hands words to decode over valid/ready, applies branch redirects.
// Optional perf counters: define FETCH_PERF_EN to enable FetchCount/RedirectCount.
//
// Handshake: a word moves to decode on a rising edge where InstrValid && InstrReady are both 1.
// While InstrValid is 1, Instr and InstrPC do not change until that transfer or a redirect.
module imem_fetch_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [63:0] PC_LIMIT    = 64'h064
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] IMemAddress,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BranchTaken,
  input  logic [63:0] BranchTarget,
  output logic        Halted,
  output logic        MisalignErr,
  output logic [31:0] FetchCount,
  output logic [31:0] RedirectCount,
  output logic [1:0]  dbg_state
);

  localparam int unsigned CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state;
  logic [63:0]   pc;
  logic [CW-1:0] wait_cnt;
  logic          transfer;
  logic          redirect_ok;

  assign IMemAddress = pc;
  assign dbg_state   = state;
  assign transfer    = (state == ST_HOLD) && InstrValid && InstrReady;
  assign redirect_ok = (state != ST_HALT) && BranchTaken && (BranchTarget[1:0] == 2'b00);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= ST_WAIT;
      pc          <= RESET_PC;
      wait_cnt    <= '0;
      Instr       <= 32'h0;
      InstrPC     <= 64'h0;
      InstrValid  <= 1'b0;
      Halted      <= 1'b0;
      MisalignErr <= 1'b0;
    end else if (state == ST_HALT) begin
      InstrValid <= 1'b0;
    end else if (BranchTaken) begin
      // Redirect wins over capture and transfer; any held or in-flight word is dropped.
      InstrValid <= 1'b0;
      wait_cnt   <= '0;
      if (BranchTarget[1:0] != 2'b00) begin
        MisalignErr <= 1'b1;
        Halted      <= 1'b1;
        state       <= ST_HALT;
      end else begin
        pc <= BranchTarget;
        if (BranchTarget >= PC_LIMIT) begin
          Halted <= 1'b1;
          state  <= ST_HALT;
        end else begin
          state <= ST_WAIT;
        end
      end
    end else if (state == ST_WAIT) begin
      if (pc >= PC_LIMIT) begin
        Halted <= 1'b1;
        state  <= ST_HALT;
      end else if (wait_cnt == LAST_CNT) begin
        Instr      <= IMemData;
        InstrPC    <= pc;
        InstrValid <= 1'b1;
        pc         <= pc + 64'd4;
        state      <= ST_HOLD;
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end else if (state == ST_HOLD) begin
      if (InstrReady) begin
        InstrValid <= 1'b0;
        wait_cnt   <= '0;
        // PC already points at the next word, so the limit is checked on the way back to WAIT.
        if (pc >= PC_LIMIT) begin
          Halted <= 1'b1;
          state  <= ST_HALT;
        end else begin
          state <= ST_WAIT;
        end
      end
    end else begin
      InstrValid <= 1'b0;
      Halted     <= 1'b1;
      state      <= ST_HALT;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      fetch_cnt    <= 32'h0;
      redirect_cnt <= 32'h0;
    end else begin
      if (transfer && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_ok && (redirect_cnt != 32'hFFFF_FFFF)) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

  assign FetchCount    = fetch_cnt;
  assign RedirectCount = redirect_cnt;
`else
  logic unused_perf;
  assign unused_perf   = transfer ^ redirect_ok;
  assign FetchCount    = 32'h0;
  assign RedirectCount = 32'h0;
`endif

endmodule
